// File: rtl/penf_pkg.sv
// Shared definitions for the one-hot term collector: FSM state encoding and
// width helpers used to size the index and count fields.
package penf_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // Width of a binary bit index into a vector of 'width' bits (never below 1).
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Width needed to hold a count from 0 up to and including 'width'.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/onehot_to_index.sv
// Combinational one-hot to binary index encoder. Each set bit ORs its index
// into the result, so a true one-hot input yields its exact bit position and
// an all-zero input yields zero.
module onehot_to_index
  import penf_pkg::*;
#(
  parameter int WIDTH = 29,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx_out
);

  // OR together the positions of all set bits.
  always_comb begin
    idx_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) begin
        idx_out = idx_out | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/onehot_term_collector.sv
// One-hot term collector: accumulates a sequence of one-hot terms into their
// OR, counts the nonzero terms and records the index of the first one. The
// result is held until the consumer takes it.
// Optional feature: define PENF_ONEHOT_CHECK_EN to enable the sticky protocol
// error flag (multi-bit term, zero term without last, non-descending order).
module onehot_term_collector
  import penf_pkg::*;
#(
  parameter int WIDTH = 29,
  localparam int IDX_W = idx_width(WIDTH),
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] oh_in,
  input  logic             last_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] vec_out,
  output logic [CNT_W-1:0] count_out,
  output logic [IDX_W-1:0] msb_idx_out,
  output logic             err_out
);

  localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             in_hs;
  logic             term_nz;
  logic [IDX_W-1:0] term_idx;

  assign in_hs   = in_valid && (state_q == COLLECT);
  assign term_nz = |oh_in;

  onehot_to_index #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .onehot  (oh_in),
    .idx_out (term_idx)
  );

  // State register; reset abandons any partially collected sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the last term moves to HOLD, the output handshake returns.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (in_hs && last_in) state_d = HOLD;
      HOLD:    if (out_ready)        state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Handshake flags depend on state only.
  always_comb begin
    in_ready  = (state_q == COLLECT);
    out_valid = (state_q == HOLD);
  end

  // Accumulator update: OR in terms, count nonzero ones, capture first index.
  always_comb begin
    vec_d   = vec_q;
    count_d = count_q;
    idx_d   = idx_q;
    if (in_hs) begin
      vec_d = vec_q | oh_in;
      if (term_nz) begin
        if (count_q < COUNT_MAX) begin
          count_d = count_q + 1'b1;
        end
        if (count_q == '0) begin
          idx_d = term_idx;
        end
      end
    end else if ((state_q == HOLD) && out_ready) begin
      vec_d   = '0;
      count_d = '0;
      idx_d   = '0;
    end
  end

  // Accumulator registers, which also serve directly as the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      vec_q   <= vec_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

  assign vec_out     = vec_q;
  assign count_out   = count_q;
  assign msb_idx_out = idx_q;

`ifdef PENF_ONEHOT_CHECK_EN
  logic             err_q, err_d;
  logic [IDX_W-1:0] prev_idx_q, prev_idx_d;
  logic             multi_bit;
  logic             order_bad;

  assign multi_bit = |(oh_in & (oh_in - WIDTH'(1)));
  assign order_bad = term_nz && (count_q != '0) && !(term_idx < prev_idx_q);

  // Sticky error and the index of the most recent nonzero term.
  always_comb begin
    err_d      = err_q;
    prev_idx_d = prev_idx_q;
    if (in_hs) begin
      if (multi_bit || (!term_nz && !last_in) || order_bad) begin
        err_d = 1'b1;
      end
      if (term_nz) begin
        prev_idx_d = term_idx;
      end
    end else if ((state_q == HOLD) && out_ready) begin
      err_d      = 1'b0;
      prev_idx_d = '0;
    end
  end

  // Error-tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q      <= 1'b0;
      prev_idx_q <= '0;
    end else begin
      err_q      <= err_d;
      prev_idx_q <= prev_idx_d;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule
